// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset PC and opcode field position.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam int          OPC_MSB      = 31;
   localparam int          OPC_LSB      = 26;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr over jmp over taken branch over fall-through.
module next_pc_calc (
   input  logic [31:0] pc,
   input  logic [25:0] instr,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jmp,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic [31:0] pc4,
   output logic        misaligned
);

   logic [31:0] br_off;

   assign pc4    = pc + 32'd4;
   assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      next_pc = pc4;
      if (jr) begin
         next_pc = jr_target;
      end else if (jmp) begin
         next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end else if (branch && branch_taken) begin
         next_pc = pc4 + br_off;
      end
   end

   // Fall-through from an aligned PC is always aligned, so this only fires on redirects.
   assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch / PC sequencing stage. Handshake: a fetch is outstanding while
// imem_req=1 in FETCH; imem_addr is held until the cycle imem_ready=1 delivers imem_rdata.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic             instr_valid,
   input  logic             retire,
   input  logic             branch,
   input  logic             branch_taken,
   input  logic             jmp,
   input  logic             jr,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic [31:0]      link_addr,
   output logic             misaligned_err,
   output logic [CNT_W-1:0] retire_count,
   output logic [1:0]       state_dbg
);

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] next_pc;
   logic [31:0] pc4;
   logic        misaligned;

   next_pc_calc u_next_pc (
      .pc           (pc_q),
      .instr        (instr_q[25:0]),
      .branch       (branch),
      .branch_taken (branch_taken),
      .jmp          (jmp),
      .jr           (jr),
      .jr_target    (jr_target),
      .next_pc      (next_pc),
      .pc4          (pc4),
      .misaligned   (misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (retire) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_req       = (state_q == ST_FETCH);
   assign imem_addr      = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[OPC_MSB:OPC_LSB];
   assign instr_valid    = (state_q == ST_EXEC);
   assign pc             = pc_q;
   assign link_addr      = pc4;
   assign misaligned_err = err_q;
   assign retire_count   = cnt_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: table of fetch/retire records plus hand sequences
// for reset, fetch stall, misaligned halt and asynchronous reset.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        retire;
   logic        branch;
   logic        branch_taken;
   logic        jmp;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        misaligned_err;
   logic [31:0] retire_count;
   logic [1:0]  state_dbg;

   int n_total = 0;
   int n_pass  = 0;

   ifetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .instr          (instr),
      .opcode         (opcode),
      .instr_valid    (instr_valid),
      .retire         (retire),
      .branch         (branch),
      .branch_taken   (branch_taken),
      .jmp            (jmp),
      .jr             (jr),
      .jr_target      (jr_target),
      .pc             (pc),
      .link_addr      (link_addr),
      .misaligned_err (misaligned_err),
      .retire_count   (retire_count),
      .state_dbg      (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic clear_ctl();
      retire = 0; branch = 0; branch_taken = 0; jmp = 0; jr = 0; jr_target = 32'd0;
   endtask

   // driver: wait for FETCH (bounded), stall lat cycles, then deliver d
   task automatic fetch_instr(input logic [31:0] d, input int lat);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (imem_req) n_pass++;
      else $display("FAIL fetch_timeout: imem_req stayed 0 for %0d cycles", n);
      for (int k = 0; k < lat; k++) begin
         imem_ready = 0;
         @(negedge clk);
      end
      imem_ready = 1;
      imem_rdata = d;
      @(negedge clk);
      imem_ready = 0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      logic        br, tk, jm, jrs;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic [31:0] rdata, input int lat, input logic br,
                               input logic tk, input logic jm, input logic jrs,
                               input logic [31:0] tgt, input logic [31:0] exp_pc,
                               input logic [31:0] exp_next);
      vec_t v;
      v.rdata = rdata; v.lat = lat; v.br = br; v.tk = tk; v.jm = jm; v.jrs = jrs;
      v.tgt = tgt; v.exp_pc = exp_pc; v.exp_next = exp_next;
      return v;
   endfunction

   logic [31:0] exp_cnt;
   logic [31:0] held_pc;

   initial begin
      vecs[0] = mk(32'h1000_FFFF, 0, 1, 1, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3000);
      vecs[1] = mk(32'h1000_FFFF, 1, 1, 0, 0, 0, 32'h0, 32'h0000_3000, 32'h0000_3004);
      vecs[2] = mk(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 32'h0000_3004, 32'h0000_3008);
      vecs[3] = mk(32'h0C00_0C10, 2, 1, 1, 1, 0, 32'h0, 32'h0000_3008, 32'h0000_3040);
      vecs[4] = mk(32'h1000_0004, 0, 1, 1, 0, 0, 32'h0, 32'h0000_3040, 32'h0000_3054);
      vecs[5] = mk(32'h0000_0008, 0, 1, 1, 1, 1, 32'h0000_1000, 32'h0000_3054, 32'h0000_1000);
      vecs[6] = mk(32'h1000_FFFE, 1, 1, 1, 0, 0, 32'h0, 32'h0000_1000, 32'h0000_0FFC);
      vecs[7] = mk(32'h0800_0000, 0, 0, 0, 1, 0, 32'h0, 32'h0000_0FFC, 32'h0000_0000);
      vecs[8] = mk(32'h0000_0008, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC);
      vecs[9] = mk(32'h2400_0001, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000);

      rst = 1; imem_ready = 0; imem_rdata = 32'd0;
      clear_ctl();

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_instr", instr, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_err", {31'd0, misaligned_err}, 32'd0);
      chk("rst_count", retire_count, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      rst = 0;
      #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, 32'h0000_3000);

      // table of fetch/execute/retire records
      exp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         fetch_instr(vecs[i].rdata, vecs[i].lat);
         chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
         chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
         chk($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, vecs[i].rdata[31:26]});
         chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("v%0d_link", i), link_addr, vecs[i].exp_pc + 32'd4);
         chk($sformatf("v%0d_req_exec", i), {31'd0, imem_req}, 32'd0);
         branch = vecs[i].br; branch_taken = vecs[i].tk; jmp = vecs[i].jm;
         jr = vecs[i].jrs; jr_target = vecs[i].tgt; retire = 1;
         @(negedge clk);
         clear_ctl();
         exp_cnt = exp_cnt + 1;
         chk($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_next);
         chk($sformatf("v%0d_count", i), retire_count, exp_cnt);
         chk($sformatf("v%0d_valid_off", i), {31'd0, instr_valid}, 32'd0);
      end

      // stalled fetch: retire pulses ignored, address held
      for (int k = 0; k < 3; k++) begin
         imem_ready = 0; retire = 1; jr = 1; jr_target = 32'h0000_0100;
         @(negedge clk);
         chk("stall_req", {31'd0, imem_req}, 32'd1);
         chk("stall_addr", imem_addr, 32'h0000_0000);
         chk("stall_valid", {31'd0, instr_valid}, 32'd0);
         chk("stall_count", retire_count, exp_cnt);
      end
      clear_ctl();
      imem_ready = 1; imem_rdata = 32'h2400_0002;
      @(negedge clk);
      imem_ready = 0;
      chk("stall_capture", instr, 32'h2400_0002);
      chk("stall_valid_on", {31'd0, instr_valid}, 32'd1);

      // misaligned redirect -> HALT
      held_pc = 32'h0000_0000;
      jr = 1; jr_target = 32'h0000_3002; retire = 1;
      @(negedge clk);
      clear_ctl();
      exp_cnt = exp_cnt + 1;
      chk("mis_err", {31'd0, misaligned_err}, 32'd1);
      chk("mis_pc", pc, held_pc);
      chk("mis_count", retire_count, exp_cnt);
      chk("mis_state", {30'd0, state_dbg}, 32'd3);
      for (int k = 0; k < 12; k++) begin
         imem_ready = 1; retire = 1;
         @(negedge clk);
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_valid", {31'd0, instr_valid}, 32'd0);
         chk("halt_pc", pc, held_pc);
         chk("halt_err", {31'd0, misaligned_err}, 32'd1);
      end
      clear_ctl();
      imem_ready = 0;

      // recover via reset, then async reset mid-EXEC
      rst = 1;
      @(negedge clk);
      chk("rec_err", {31'd0, misaligned_err}, 32'd0);
      rst = 0;
      fetch_instr(32'h0000_0000, 0);
      retire = 1;
      @(negedge clk);
      clear_ctl();
      chk("rec_pc", pc, 32'h0000_3004);
      chk("rec_count", retire_count, 32'd1);
      fetch_instr(32'h2400_0003, 1);
      chk("pre_async_valid", {31'd0, instr_valid}, 32'd1);
      #2 rst = 1;
      #1;
      chk("async_pc", pc, 32'h0000_3000);
      chk("async_valid", {31'd0, instr_valid}, 32'd0);
      chk("async_count", retire_count, 32'd0);
      chk("async_instr", instr, 32'd0);
      chk("async_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      // report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch and PC-sequencing stage that sits directly upstream of the opcode decoder. It owns the PC and fetches each instruction over a ready-handshaked instruction-memory port. It presents the instruction and its opcode field to the decoder, then consumes the decoder's branch/jmp/jr outputs plus the branch condition to select the next PC. Misaligned redirect targets halt fetch.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; high only in FETCH
imem_addr  out  32  byte address of fetch, equals pc
imem_rdata  in  32  instruction word; valid when imem_ready=1
imem_ready  in  1  memory has returned imem_rdata this cycle
instr  out  32  registered current instruction
opcode  out  6  instr[31:26], drives decoder opCode
instr_valid  out  1  instr held and executing (EXEC state)
retire  in  1  core finished current instruction; apply next PC
branch  in  1  decoder branch control
branch_taken  in  1  branch condition result from ALU
jmp  in  1  decoder jump control (j/jal)
jr  in  1  register-jump select (jr/jalr)
jr_target  in  32  register value for jr
pc  out  32  address of current instruction
link_addr  out  32  pc+4, return address for jal/bltzal/bgezal
misaligned_err  out  1  sticky; redirect target low bits nonzero
retire_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, misaligned_err=0, retire_count=0. imem_req=0 while rst is high.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE -> FETCH on the first clock after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready. On imem_ready: instr<=imem_rdata, state->EXEC, instr_valid=1 next cycle. Fetch latency is 1 cycle minimum and unbounded.
- EXEC: imem_ready is ignored. On retire: compute next PC, retire_count+=1 (wraps at 2^CNT_W).
  - If next PC[1:0]!=0: state->HALT, misaligned_err<=1, pc unchanged.
  - Otherwise pc<=next PC, state->FETCH, instr_valid<=0.
- A retire pulse outside EXEC is ignored.
- HALT: imem_req=0 and instr_valid=0. Held until reset.
- Next-PC priority, combinational:
  1. jr -> jr_target
  2. jmp -> {pc4[31:28], instr[25:0], 2'b00}
  3. branch & branch_taken -> pc4 + (sext(instr[15:0]) << 2)
  4. else -> pc4
- pc4 = pc+4. All additions are modulo 2^32 and wrap silently.
- Branch with branch_taken=0 gives pc4. No delay slot.
- link_addr = pc4, combinational, valid whenever instr_valid=1.
- opcode = instr[31:26] at all times; it is 0 after reset.
- Misalignment is checked only on redirect targets; pc4 from an aligned PC is always aligned. RESET_PC must be word-aligned.

Decomposition:
- Shared package cpu_pkg: state encoding (IDLE, FETCH, EXEC, HALT), RESET_PC default, opcode field position constants (OPC_MSB=31, OPC_LSB=26).
- One combinational sub-module, next_pc_calc: inputs pc, instr, branch, branch_taken, jmp, jr, jr_target; outputs next_pc, pc4, misaligned.
- The FSM, counter and registers stay in ifetch_unit.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=0x00000000, retire pulsed in each EXEC -> pc sequence 0x3000, 0x3004, 0x3008; retire_count=3; imem_req low during rst and the IDLE cycle.
- pc=0x3000, instr=0x1000FFFF, branch=1, branch_taken=1, retire -> pc=0x3000. Same with branch_taken=0 -> pc=0x3004.
- pc=0x3008, instr=0x0C000C10 (jal), jmp=1, branch=1 also asserted -> pc=0x00003040 (jmp wins over branch); link_addr=0x0000300C during EXEC.
- jr=1, jr_target=0x00003002, retire -> HALT, misaligned_err=1, pc stays, imem_req=0 for 10+ cycles, recovers only after rst.
- imem_ready held 0 for 3 cycles in FETCH with retire pulsed -> imem_req=1, imem_addr stable, instr_valid=0, retire_count unchanged. Ready on 4th cycle -> instr captured.
- rst asserted mid-EXEC between clock edges -> pc=RESET_PC, instr_valid=0, retire_count=0 immediately, no clock edge needed.
